e_pipe_reg: RTL and testbench



---
 rtl/e_pipe_reg_pkg.sv | 41 ++++
 rtl/e_pipe_reg_load_use_detect.sv | 25 ++
 rtl/e_pipe_reg.sv | 103 ++++++++++
 tb/tb_e_pipe_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/e_pipe_reg_pkg.sv
// Shared opcode constants and the E-stage field bundle for the decode-to-execute register.
package e_pipe_reg_pkg;

    localparam logic [5:0] IROP  = 6'h00;
    localparam logic [5:0] IJ    = 6'h02;
    localparam logic [5:0] IADDI = 6'h08;
    localparam logic [5:0] IORI  = 6'h0D;
    localparam logic [5:0] ILW   = 6'h23;
    localparam logic [5:0] ISW   = 6'h2B;

    // A NOP is encoded as sll $0,$0,0: R-type with a zero function field.
    localparam logic [5:0] INOP     = IROP;
    localparam logic [5:0] NOP_FUNC = 6'h00;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [31:0] val_a;
        logic [31:0] val_b;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  dst_e;
        logic        valid;
    } e_fields_t;

    localparam e_fields_t BUBBLE = '{
        op:    INOP,
        func:  NOP_FUNC,
        val_a: 32'd0,
        val_b: 32'd0,
        imm:   32'd0,
        pc:    32'd0,
        dst_e: 5'd0,
        valid: 1'b0
    };

    function automatic logic uses_b(input logic [5:0] op);
        return (op == IROP) || (op == ISW);
    endfunction

endpackage

// File: rtl/e_pipe_reg_load_use_detect.sv
// Combinational load-use hazard check between the instruction in E and the one in D.
module load_use_detect
    import e_pipe_reg_pkg::*;
(
    input  logic       e_valid_i,
    input  logic [5:0] e_op_i,
    input  logic [4:0] e_dst_i,
    input  logic       d_valid_i,
    input  logic [5:0] d_op_i,
    input  logic [4:0] d_src_a_i,
    input  logic [4:0] d_src_b_i,
    output logic       load_use_o
);

    logic e_is_load;
    logic hit_a;
    logic hit_b;

    // Register 0 is never a real producer, so a load into $0 cannot create a hazard.
    assign e_is_load  = e_valid_i && (e_op_i == ILW) && (e_dst_i != 5'd0);
    assign hit_a      = (e_dst_i == d_src_a_i);
    assign hit_b      = uses_b(d_op_i) && (e_dst_i == d_src_b_i);
    assign load_use_o = e_is_load && d_valid_i && (hit_a || hit_b);

endmodule

// File: rtl/e_pipe_reg.sv
// Decode-to-execute pipeline register: load, hold or bubble the E stage, plus perf counters.
module e_pipe_reg
    import e_pipe_reg_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       d_op,
    input  logic [5:0]       d_func,
    input  logic [31:0]      d_valA,
    input  logic [31:0]      d_valB,
    input  logic [31:0]      d_imm,
    input  logic [31:0]      d_pc,
    input  logic [4:0]       d_srcA,
    input  logic [4:0]       d_srcB,
    input  logic [4:0]       d_dstE,
    input  logic             d_valid,
    input  logic             e_flush,
    input  logic             m_stall,
    output logic [5:0]       E_op,
    output logic [5:0]       E_func,
    output logic [31:0]      E_valA,
    output logic [31:0]      E_valB,
    output logic [31:0]      E_imm,
    output logic [31:0]      E_pc,
    output logic [4:0]       E_dstE,
    output logic             E_valid,
    output logic             load_use,
    output logic             fd_stall,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    e_fields_t        e_q, e_d, d_fields;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign d_fields = '{
        op:    d_op,
        func:  d_func,
        val_a: d_valA,
        val_b: d_valB,
        imm:   d_imm,
        pc:    d_pc,
        dst_e: d_dstE,
        valid: d_valid
    };

    load_use_detect u_load_use_detect (
        .e_valid_i  (e_q.valid),
        .e_op_i     (e_q.op),
        .e_dst_i    (e_q.dst_e),
        .d_valid_i  (d_valid),
        .d_op_i     (d_op),
        .d_src_a_i  (d_srcA),
        .d_src_b_i  (d_srcB),
        .load_use_o (load_use)
    );

    // On a coincident flush, D is being discarded upstream, so there is nothing to hold.
    assign fd_stall = m_stall | (load_use & ~e_flush);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        e_d          = e_q;
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (m_stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else if (e_flush || load_use) begin
            e_d = BUBBLE;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else begin
            e_d = d_fields;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_q          <= BUBBLE;
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            e_q          <= e_d;
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign E_op       = e_q.op;
    assign E_func     = e_q.func;
    assign E_valA     = e_q.val_a;
    assign E_valB     = e_q.val_b;
    assign E_imm      = e_q.imm;
    assign E_pc       = e_q.pc;
    assign E_dstE     = e_q.dst_e;
    assign E_valid    = e_q.valid;
    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_e_pipe_reg.sv
// Scoreboard bench for e_pipe_reg: directed test-plan scenarios followed by random traffic.
module tb_e_pipe_reg;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic [5:0]    d_op = '0, d_func = '0;
    logic [31:0]   d_valA = '0, d_valB = '0, d_imm = '0, d_pc = '0;
    logic [4:0]    d_srcA = '0, d_srcB = '0, d_dstE = '0;
    logic          d_valid = 1'b0, e_flush = 1'b0, m_stall = 1'b0;
    logic [5:0]    E_op, E_func;
    logic [31:0]   E_valA, E_valB, E_imm, E_pc;
    logic [4:0]    E_dstE;
    logic          E_valid, load_use, fd_stall;
    logic [CW-1:0] bubble_cnt, stall_cnt;

    e_pipe_reg #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_op(d_op), .d_func(d_func), .d_valA(d_valA), .d_valB(d_valB),
        .d_imm(d_imm), .d_pc(d_pc), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_dstE(d_dstE), .d_valid(d_valid), .e_flush(e_flush), .m_stall(m_stall),
        .E_op(E_op), .E_func(E_func), .E_valA(E_valA), .E_valB(E_valB),
        .E_imm(E_imm), .E_pc(E_pc), .E_dstE(E_dstE), .E_valid(E_valid),
        .load_use(load_use), .fd_stall(fd_stall),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [5:0]  op, func;
        logic [31:0] a, b, imm, pc;
        logic [4:0]  dst;
        logic        valid;
        int          bub, stl;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   total = 0;
    int   bad = 0;
    logic lu_seen, fs_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        return (x + 1 > CMAX) ? CMAX : x + 1;
    endfunction

    function automatic exp_t make_bubble(input exp_t cur);
        exp_t r = cur;
        r.op = OP_R; r.func = '0; r.a = '0; r.b = '0; r.imm = '0; r.pc = '0;
        r.dst = '0; r.valid = 1'b0;
        return r;
    endfunction

    // One D-stage cycle: apply inputs, check the combinational outputs, queue the next E state.
    task automatic drive(input logic rst, input logic [5:0] op, input logic [4:0] sa, sb, dst,
                         input logic valid, flush, stall, input logic [31:0] b, imm);
        logic hz;
        @(negedge clk);
        rst_n = rst; d_op = op; d_srcA = sa; d_srcB = sb; d_dstE = dst; d_valid = valid;
        e_flush = flush; m_stall = stall; d_valB = b; d_imm = imm;
        d_func = 6'($urandom); d_valA = $urandom; d_pc = $urandom;
        #1;
        hz = m.valid && m.op == OP_LW && m.dst != 0 && valid &&
             (m.dst == sa || ((op == OP_R || op == OP_SW) && m.dst == sb));
        lu_seen = load_use;
        fs_seen = fd_stall;
        check("load_use", load_use, hz);
        check("fd_stall", fd_stall, stall | (hz & ~flush));
        if (!rst) begin
            m = make_bubble(m); m.bub = 0; m.stl = 0;
        end else if (stall) begin
            m.stl = sat(m.stl);
        end else if (flush || hz) begin
            m = make_bubble(m); m.bub = sat(m.bub);
        end else begin
            m.op = op; m.func = d_func; m.a = d_valA; m.b = b; m.imm = imm; m.pc = d_pc;
            m.dst = dst; m.valid = valid;
        end
        q.push_back(m);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("E_op", E_op, e.op);
                check("E_func", E_func, e.func);
                check("E_valA", E_valA, e.a);
                check("E_valB", E_valB, e.b);
                check("E_imm", E_imm, e.imm);
                check("E_pc", E_pc, e.pc);
                check("E_dstE", E_dstE, e.dst);
                check("E_valid", E_valid, e.valid);
                check("bubble_cnt", bubble_cnt, e.bub);
                check("stall_cnt", stall_cnt, e.stl);
            end
        end
    end

    initial begin : stim
        logic [5:0] ops [6] = '{OP_R, OP_J, OP_ADDI, OP_ORI, OP_LW, OP_SW};
        m = '{op: OP_R, func: 0, a: 0, b: 0, imm: 0, pc: 0, dst: 0, valid: 0, bub: 0, stl: 0};

        // Reset with a live instruction on D.
        repeat (2) drive(1'b0, OP_ADDI, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
        after_edge();
        check("reset_op", E_op, OP_R);
        check("reset_valid", E_valid, 1'b0);
        check("reset_cnts", {bubble_cnt, stall_cnt}, '0);

        // Straight load.
        drive(1'b1, OP_ADDI, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 32'd35, 32'd7);
        after_edge();
        check("load_op", E_op, OP_ADDI);
        check("load_valB", E_valB, 32'd35);
        check("load_imm", E_imm, 32'd7);
        check("load_valid", E_valid, 1'b1);

        // Load followed by a dependent R-type: one bubble, then it enters E.
        drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'd4);
        drive(1'b1, OP_R, 5'd1, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 32'd11, 32'd0);
        check("lu_hazard", lu_seen, 1'b1);
        check("lu_fd_stall", fs_seen, 1'b1);
        after_edge();
        check("lu_bubble_valid", E_valid, 1'b0);
        check("lu_bubble_cnt", bubble_cnt, 4'd1);
        drive(1'b1, OP_R, 5'd1, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 32'd11, 32'd0);
        check("lu_cleared", lu_seen, 1'b0);
        after_edge();
        check("lu_reload_op", E_op, OP_R);
        check("lu_reload_valid", E_valid, 1'b1);

        // ORI reads only rs, so a matching rt is not a hazard.
        drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 32'd4);
        drive(1'b1, OP_ORI, 5'd2, 5'd9, 5'd12, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
        check("ori_no_hazard", lu_seen, 1'b0);

        // Memory stall with a pending flush, then the flush lands once the stall drops.
        repeat (3) drive(1'b1, OP_ADDI, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'd1, 32'd1);
        after_edge();
        check("stall_cnt3", stall_cnt, 4'd3);
        check("stall_hold_op", E_op, OP_ORI);
        drive(1'b1, OP_ADDI, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
        check("flush_fd_stall", fs_seen, 1'b0);
        after_edge();
        check("flush_bubble", E_valid, 1'b0);

        // Saturation of the bubble counter.
        repeat (20) drive(1'b1, OP_ADDI, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
        after_edge();
        check("bubble_sat", bubble_cnt, 4'd15);

        // Random traffic with small register numbers so hazards are frequent.
        drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) >= 2), ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
                  $urandom, $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
